// File: rtl/masked_and_ctrl_if.sv
// Handshake bundle between plain-domain control, the masked AND controller and the gadget.
// slave = controller view, master = environment (requester, result consumer, gadget).
interface masked_and_ctrl_if #(
  parameter int D = 2
);
  localparam int RINW = D * (D - 1) / 2;
  localparam int RNDW = 2 * (D - 1) + RINW;

  logic            in_valid;
  logic            in_ready;
  logic            a;
  logic            b;
  logic [RNDW-1:0] rnd_in;

  logic            res_valid;
  logic            res_ready;
  logic            result;
  logic [D-1:0]    result_shares;
  logic            res_err;

  logic [D-1:0]    and_ina;
  logic [D-1:0]    and_inb;
  logic [RINW-1:0] and_rin;
  logic            and_enable;
  logic            and_done;
  logic [D-1:0]    and_out;

  modport slave (
    input  in_valid, a, b, rnd_in, res_ready, and_done, and_out,
    output in_ready, res_valid, result, result_shares, res_err,
           and_ina, and_inb, and_rin, and_enable
  );

  modport master (
    output in_valid, a, b, rnd_in, res_ready, and_done, and_out,
    input  in_ready, res_valid, result, result_shares, res_err,
           and_ina, and_inb, and_rin, and_enable
  );
endinterface

// File: rtl/masked_and_ctrl.sv
// Masks a/b into D shares, runs the AND gadget until done or timeout; result N+1 edges after transfer.
// in_ready only in IDLE; result held in HOLD until res_ready; gadget inputs are zero outside RUN.
module masked_and_ctrl #(
  parameter int D       = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  masked_and_ctrl_if.slave  bus
);
  localparam int RINW = D * (D - 1) / 2;
  localparam int RNDW = 2 * (D - 1) + RINW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    ina_q, ina_d;
  logic [D-1:0]    inb_q, inb_d;
  logic [RINW-1:0] rin_q, rin_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            res_q, res_d;
  logic [D-1:0]    rsh_q, rsh_d;
  logic            err_q, err_d;

  logic [D-1:0]    split_a;
  logic [D-1:0]    split_b;
  logic            par_a;
  logic            par_b;

  // Last share absorbs the operand so the unmasked bit never reaches a register.
  always_comb begin
    split_a = '0;
    split_b = '0;
    par_a   = bus.a;
    par_b   = bus.b;
    for (int i = 0; i < D - 1; i++) begin
      split_a[i] = bus.rnd_in[i];
      split_b[i] = bus.rnd_in[D - 1 + i];
      par_a      = par_a ^ bus.rnd_in[i];
      par_b      = par_b ^ bus.rnd_in[D - 1 + i];
    end
    split_a[D-1] = par_a;
    split_b[D-1] = par_b;
  end

  always_comb begin
    state_d = state_q;
    ina_d   = ina_q;
    inb_d   = inb_q;
    rin_d   = rin_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rsh_d   = rsh_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          ina_d   = split_a;
          inb_d   = split_b;
          rin_d   = bus.rnd_in[RNDW-1:2*(D-1)];
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 8'd1;
        // done wins over a timeout landing on the same edge
        if (bus.and_done) begin
          state_d = HOLD;
          res_d   = ^bus.and_out;
          rsh_d   = bus.and_out;
          err_d   = 1'b0;
          ina_d   = '0;
          inb_d   = '0;
          rin_d   = '0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = HOLD;
          res_d   = 1'b0;
          rsh_d   = '0;
          err_d   = 1'b1;
          ina_d   = '0;
          inb_d   = '0;
          rin_d   = '0;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ina_d   = '0;
        inb_d   = '0;
        rin_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ina_q   <= '0;
      inb_q   <= '0;
      rin_q   <= '0;
      cnt_q   <= '0;
      res_q   <= 1'b0;
      rsh_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ina_q   <= ina_d;
      inb_q   <= inb_d;
      rin_q   <= rin_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rsh_q   <= rsh_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode the state register, so reset clears them without a clock.
  assign bus.in_ready      = (state_q == IDLE);
  assign bus.res_valid     = (state_q == HOLD);
  assign bus.and_enable    = (state_q == RUN);
  assign bus.result        = res_q;
  assign bus.result_shares = rsh_q;
  assign bus.res_err       = err_q;
  assign bus.and_ina       = ina_q;
  assign bus.and_inb       = inb_q;
  assign bus.and_rin       = rin_q;

endmodule

// File: tb/tb_masked_and_ctrl.sv
// Directed bench for masked_and_ctrl with a D=2 gadget stub of programmable done latency.
module tb_masked_and_ctrl;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   lat;
  int   cnt_s;
  logic done_s;

  masked_and_ctrl_if #(.D(2)) bus ();

  masked_and_ctrl #(.D(2), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub gadget: pulses done after lat enabled edges (lat=0: never), counter carries over.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_s  <= 0;
      done_s <= 1'b0;
    end else if (bus.and_enable && !done_s && lat != 0) begin
      if (cnt_s == lat - 1) begin
        done_s <= 1'b1;
        cnt_s  <= 0;
      end else begin
        cnt_s <= cnt_s + 1;
      end
    end else begin
      done_s <= 1'b0;
    end
  end

  assign bus.and_done = done_s;
  assign bus.and_out  = done_s ? {((^bus.and_ina) & (^bus.and_inb)) ^ bus.and_rin[0], bus.and_rin[0]}
                               : 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic a, input logic b, input logic [2:0] r, input int l,
                       input int exp_edges, input logic exp_err, input int hold_cyc);
    int       k;
    logic [1:0] e_ina;
    logic [1:0] e_inb;
    logic     e_res;
    logic [1:0] cap_sh;
    logic     cap_res;
    e_ina = {a ^ r[0], r[0]};
    e_inb = {b ^ r[1], r[1]};
    e_res = exp_err ? 1'b0 : (a & b);
    lat   = l;
    bus.res_ready = (hold_cyc == 0);
    bus.a = a;
    bus.b = b;
    bus.rnd_in = r;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 1'b0;
    bus.b = 1'b0;
    chk("in_ready_fall", 32'(bus.in_ready), 32'(0));
    chk("enable_rise", 32'(bus.and_enable), 32'(1));
    chk("ina", 32'(bus.and_ina), 32'(e_ina));
    chk("inb", 32'(bus.and_inb), 32'(e_inb));
    chk("rin", 32'(bus.and_rin), 32'(r[2]));
    k = 0;
    while (!bus.res_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (!bus.res_valid) begin
        chk("run_held", 32'({bus.and_enable, bus.and_ina, bus.and_inb, bus.and_rin}),
            32'({1'b1, e_ina, e_inb, r[2]}));
      end
    end
    chk("latency", 32'(k), 32'(exp_edges));
    chk("res_err", 32'(bus.res_err), 32'(exp_err));
    chk("result", 32'(bus.result), 32'(e_res));
    chk("shares_xor", 32'(^bus.result_shares), 32'(e_res));
    if (exp_err) chk("shares_zero", 32'(bus.result_shares), 32'(0));
    chk("enable_fall", 32'(bus.and_enable), 32'(0));
    chk("leak_zero", 32'({bus.and_ina, bus.and_inb, bus.and_rin}), 32'(0));
    cap_sh  = bus.result_shares;
    cap_res = bus.result;
    if (hold_cyc > 0) begin
      bus.in_valid = 1'b1;
      bus.rnd_in = 3'b111;
      for (int i = 0; i < hold_cyc; i++) begin
        @(posedge clk); #1;
        chk("hold_stable", 32'({bus.res_valid, bus.in_ready, bus.res_err, bus.result, bus.result_shares}),
            32'({1'b1, 1'b0, exp_err, cap_res, cap_sh}));
      end
      bus.in_valid = 1'b0;
      bus.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("accept", 32'({bus.res_valid, bus.in_ready, bus.res_err}), 32'({1'b0, 1'b1, 1'b0}));
    bus.res_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    lat = 3;
    bus.in_valid = 1'b0;
    bus.a = 1'b0;
    bus.b = 1'b0;
    bus.rnd_in = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'({bus.in_ready, bus.res_valid, bus.result, bus.result_shares, bus.res_err,
                          bus.and_enable, bus.and_ina, bus.and_inb, bus.and_rin}),
        32'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0}));
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // r=101, a=b=1: ina={0,1}, inb={1,0}, rin=1; fixed latency 3 -> valid at edge 4
    lat = 3;
    bus.res_ready = 1'b1;
    bus.a = 1'b1;
    bus.b = 1'b1;
    bus.rnd_in = 3'b101;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("v0_ina", 32'(bus.and_ina), 32'(2'b01));
    chk("v0_inb", 32'(bus.and_inb), 32'(2'b10));
    chk("v0_rin", 32'(bus.and_rin), 32'(1'b1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("v0_not_yet", 32'(bus.res_valid), 32'(0));
    end
    @(posedge clk); #1;
    chk("v0_valid_edge4", 32'(bus.res_valid), 32'(1));
    chk("v0_result", 32'(bus.result), 32'(1));
    chk("v0_shares_xor", 32'(^bus.result_shares), 32'(1));
    @(posedge clk); #1;
    chk("v0_accept", 32'(bus.in_ready), 32'(1));
    bus.res_ready = 1'b0;

    // Full a/b x rnd sweep, res_ready high, latency alternating 3/2
    for (int ab = 0; ab < 4; ab++) begin
      for (int r = 0; r < 8; r++) begin
        do_op(ab[1], ab[0], 3'(r), (r % 2 == 0) ? 3 : 2, (r % 2 == 0) ? 4 : 3, 1'b0, 0);
      end
    end

    // Backpressure: five stalled HOLD cycles, in_valid asserted meanwhile
    do_op(1'b1, 1'b1, 3'b011, 3, 4, 1'b0, 5);
    do_op(1'b1, 1'b0, 3'b110, 2, 3, 1'b0, 5);

    // Never-done gadget -> timeout at edge TIMEOUT
    do_op(1'b1, 1'b1, 3'b010, 0, TIMEOUT, 1'b1, 2);
    // done coincident with timeout edge -> valid result, no error
    do_op(1'b1, 1'b1, 3'b100, TIMEOUT - 1, TIMEOUT, 1'b0, 0);
    // done one edge too late -> timeout, late done ignored in HOLD
    do_op(1'b1, 1'b1, 3'b001, TIMEOUT, TIMEOUT, 1'b1, 3);

    // Asynchronous reset mid-RUN
    lat = 3;
    bus.a = 1'b1;
    bus.b = 1'b1;
    bus.rnd_in = 3'b111;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_clear", 32'({bus.and_enable, bus.and_ina, bus.and_inb, bus.and_rin, bus.res_valid, bus.in_ready}),
        32'({1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release", 32'({bus.in_ready, bus.and_enable}), 32'({1'b1, 1'b0}));
    do_op(1'b1, 1'b1, 3'b101, 3, 4, 1'b0, 0);
    do_op(1'b0, 1'b1, 3'b011, 2, 3, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

endmodule
